// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared format constants, classes and helpers for the fp add/sub unit
package fp_pkg;
  localparam int EXP_W_DEF   = 8;
  localparam int FRAC_W_DEF  = 23;
  localparam int W_DEF       = 1 + EXP_W_DEF + FRAC_W_DEF;
  localparam int BIAS_DEF    = (1 << (EXP_W_DEF - 1)) - 1;
  localparam int EXP_MAX_DEF = (1 << EXP_W_DEF) - 1;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  typedef struct packed {
    logic                  sign;
    logic [EXP_W_DEF-1:0]  exp;
    logic [FRAC_W_DEF:0]   sig;
    fp_class_e             cls;
  } fp_unpacked_t;

  function automatic logic [127:0] canon_qnan(input int exp_w, input int frac_w);
    logic [127:0] q;
    q = ((128'(1) << exp_w) - 128'(1)) << frac_w;
    q = q | (128'(1) << (frac_w - 1));
    return q;
  endfunction

  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_nz);
    if (exp_zero) return FP_ZERO;
    if (exp_ones) return frac_nz ? FP_NAN : FP_INF;
    return FP_NORM;
  endfunction

  // Subnormals are flushed: a zero exponent always yields a zero significand.
  function automatic fp_unpacked_t unpack(input logic [W_DEF-1:0] x);
    fp_unpacked_t u;
    u.sign = x[W_DEF-1];
    u.exp  = x[W_DEF-2:FRAC_W_DEF];
    u.cls  = classify(u.exp == '0, u.exp == '1, x[FRAC_W_DEF-1:0] != '0);
    u.sig  = (u.cls == FP_NORM) ? {1'b1, x[FRAC_W_DEF-1:0]} : '0;
    return u;
  endfunction
endpackage

// File: rtl/fp_addsub_pipe_lzc.sv
// rtl/fp_addsub_pipe_lzc.sv - parametrised leading-zero counter with all-zero flag
module fp_lzc #(
  parameter  int N  = 27,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0]  data,
  output logic [CW-1:0] count,
  output logic          zero
);
  // Scan upward so the highest set bit wins.
  always_comb begin
    count = '0;
    zero  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (data[i]) begin
        count = CW'(N - 1 - i);
        zero  = 1'b0;
      end
    end
  end
endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - pipelined RNE floating-point add/subtract with valid/ready
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W  = EXP_W_DEF,
  parameter  int FRAC_W = FRAC_W_DEF,
  localparam int W      = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int M  = FRAC_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int CW = $clog2(M);
  localparam int XE = EXP_W + 2;   // signed working exponent
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = W'(canon_qnan(EXP_W, FRAC_W));

  logic en;
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  logic s0_valid, s1_valid, s2_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (en) begin
      s0_valid <= in_valid;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
    end
  end

  logic [W-1:0] s0_a, s0_b;
  logic         s0_sub;
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      s0_a   <= op1;
      s0_b   <= op2;
      s0_sub <= sub;
    end
  end

  // S1: classify, order by magnitude, align the smaller operand
  logic              sa, sb, swap, sl;
  logic [EXP_W-1:0]  ea, eb, el, es, d;
  logic [FRAC_W-1:0] fa, fb;
  logic [FRAC_W:0]   siga, sigb, sigl, sigs;
  fp_class_e         ca, cb;
  logic [M-1:0]      ext_s, al;
  logic              sp;
  logic [W-1:0]      sp_res;
  logic              sp_inv;

  assign sa   = s0_a[W-1];
  assign sb   = s0_b[W-1] ^ s0_sub;
  assign ea   = s0_a[W-2:FRAC_W];
  assign eb   = s0_b[W-2:FRAC_W];
  assign fa   = s0_a[FRAC_W-1:0];
  assign fb   = s0_b[FRAC_W-1:0];
  assign ca   = classify(ea == '0, ea == EXP_ONES, fa != '0);
  assign cb   = classify(eb == '0, eb == EXP_ONES, fb != '0);
  assign siga = (ca == FP_NORM) ? {1'b1, fa} : '0;
  assign sigb = (cb == FP_NORM) ? {1'b1, fb} : '0;
  assign swap = s0_b[W-2:0] > s0_a[W-2:0];
  assign sl   = swap ? sb : sa;
  assign el   = swap ? eb : ea;
  assign es   = swap ? ea : eb;
  assign sigl = swap ? sigb : siga;
  assign sigs = swap ? siga : sigb;
  assign d    = el - es;

  always_comb begin
    ext_s = {sigs, 3'b000};
    if (32'(d) >= FRAC_W + 3) al = M'(|sigs);
    else al = (ext_s >> d) | M'(|(ext_s & ~({M{1'b1}} << d)));
  end

  always_comb begin
    sp     = 1'b0;
    sp_res = '0;
    sp_inv = 1'b0;
    if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_INF && sa != sb)) begin
      sp     = 1'b1;
      sp_res = QNAN;
      sp_inv = 1'b1;
    end else if (ca == FP_INF) begin
      sp     = 1'b1;
      sp_res = {sa, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (cb == FP_INF) begin
      sp     = 1'b1;
      sp_res = {sb, EXP_ONES, {FRAC_W{1'b0}}};
    end
  end

  logic             s1_sp, s1_sp_inv, s1_sign, s1_eff_sub;
  logic [W-1:0]     s1_sp_res;
  logic [EXP_W-1:0] s1_exp;
  logic [M-1:0]     s1_big, s1_small;
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sp      <= sp;
      s1_sp_res  <= sp_res;
      s1_sp_inv  <= sp_inv;
      s1_sign    <= sl;
      s1_eff_sub <= sa ^ sb;
      s1_exp     <= el;
      s1_big     <= {sigl, 3'b000};
      s1_small   <= al;
    end
  end

  // S2: add or subtract, fold a carry-out back into range, count leading zeros
  logic [M:0]            sum;
  logic [M-1:0]          mant2;
  logic signed [XE-1:0]  exp2;
  logic [CW-1:0]         lz;
  logic                  lz_zero;

  always_comb begin
    if (s1_eff_sub) sum = {1'b0, s1_big - s1_small};
    else            sum = {1'b0, s1_big} + {1'b0, s1_small};
    mant2 = sum[M] ? {sum[M:2], sum[1] | sum[0]} : sum[M-1:0];
    exp2  = $signed({2'b00, s1_exp}) + $signed({{(XE-1){1'b0}}, sum[M]});
  end

  fp_lzc #(.N(M)) u_lzc (
    .data  (mant2),
    .count (lz),
    .zero  (lz_zero)
  );

  logic                  s2_sp, s2_sp_inv, s2_sign, s2_eff_sub, s2_zero;
  logic [W-1:0]          s2_sp_res;
  logic signed [XE-1:0]  s2_exp;
  logic [M-1:0]          s2_mant;
  logic [CW-1:0]         s2_lz;
  always_ff @(posedge clk) begin
    if (en) begin
      s2_sp      <= s1_sp;
      s2_sp_res  <= s1_sp_res;
      s2_sp_inv  <= s1_sp_inv;
      s2_sign    <= s1_sign;
      s2_eff_sub <= s1_eff_sub;
      s2_zero    <= lz_zero;
      s2_exp     <= exp2;
      s2_mant    <= mant2;
      s2_lz      <= lz;
    end
  end

  // S3: normalise, round to nearest even, pack
  logic [M-2:0]          mant_n;
  logic signed [XE-1:0]  exp_n, exp_r;
  logic                  g, r, st, up, r_carry;
  logic [FRAC_W-1:0]     frac_r;
  logic [W-1:0]          res;
  logic [3:0]            flg;

  always_comb begin
    mant_n            = (M-1)'(s2_mant << s2_lz);
    exp_n             = s2_exp - $signed({{(XE-CW){1'b0}}, s2_lz});
    g                 = mant_n[2];
    r                 = mant_n[1];
    st                = mant_n[0];
    up                = g & (r | st | mant_n[3]);
    {r_carry, frac_r} = {1'b0, mant_n[M-2:3]} + {{FRAC_W{1'b0}}, up};
    exp_r             = exp_n + $signed({{(XE-1){1'b0}}, r_carry});
    res = '0;
    flg = '0;
    if (s2_sp) begin
      res               = s2_sp_res;
      flg[FLAG_INVALID] = s2_sp_inv;
    end else if (s2_zero) begin
      res = {s2_sign & ~s2_eff_sub, {(W-1){1'b0}}};
    end else if (exp_n <= 0) begin
      res                 = {s2_sign, {(W-1){1'b0}}};
      flg[FLAG_UNDERFLOW] = 1'b1;
      flg[FLAG_INEXACT]   = 1'b1;
    end else if (exp_r >= $signed({2'b00, EXP_ONES})) begin
      res                = {s2_sign, EXP_ONES, {FRAC_W{1'b0}}};
      flg[FLAG_OVERFLOW] = 1'b1;
      flg[FLAG_INEXACT]  = 1'b1;
    end else begin
      res               = {s2_sign, exp_r[EXP_W-1:0], frac_r};
      flg[FLAG_INEXACT] = g | r | st;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= res;
        flags  <= flg;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - self-checking bench for fp_addsub_pipe
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];

  fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // Exact rational sum on a wide integer grid, then RNE to single precision.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic sa, sb, rs, up, inx;
    int ea, eb, p, e, sh;
    logic [22:0] fa, fb;
    logic [319:0] ma, mb, mag, rem, half;
    logic [24:0] keep;
    sa = a[31]; sb = b[31] ^ s;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
        (ea == 255 && eb == 255 && sa != sb)) return {32'h7FC00000, 4'b1000};
    if (ea == 255) return {sa, 8'hFF, 23'd0, 4'b0000};
    if (eb == 255) return {sb, 8'hFF, 23'd0, 4'b0000};
    ma = (ea == 0) ? '0 : (320'({1'b1, fa}) << (ea - 1));
    mb = (eb == 0) ? '0 : (320'({1'b1, fb}) << (eb - 1));
    if (sa == sb)      begin mag = ma + mb; rs = sa; end
    else if (ma >= mb) begin mag = ma - mb; rs = sa; end
    else               begin mag = mb - ma; rs = sb; end
    if (mag == 0) return {(sa == sb) ? sa : 1'b0, 31'd0, 4'b0000};
    p = 0;
    for (int i = 319; i >= 0; i--) if (mag[i]) begin p = i; break; end
    e = p - 22;
    if (e <= 0) return {rs, 31'd0, 4'b0011};
    sh   = p - 23;
    keep = 25'(mag >> sh);
    rem  = mag & ((320'(1) << sh) - 320'(1));
    half = (sh > 0) ? (320'(1) << (sh - 1)) : '0;
    inx  = (rem != 0);
    up   = (sh > 0) && ((rem > half) || (rem == half && keep[0]));
    keep = keep + 25'(up);
    if (keep[24]) begin keep = keep >> 1; e++; end
    if (e >= 255) return {rs, 8'hFF, 23'd0, 4'b0101};
    return {rs, 8'(e), keep[22:0], 3'b000, inx};
  endfunction

  function automatic logic [31:0] rnd_num(input int emin, input int emax);
    return {1'($urandom), 8'($urandom_range(emax, emin)), 23'($urandom)};
  endfunction

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic ordy, input logic [35:0] expv, input logic use_model,
                      output logic acc);
    in_valid = v; op1 = a; op2 = b; sub = s; out_ready = ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 64'(exp_q.size()), 64'd1);
      else begin
        check("result", 64'(result), 64'(exp_q[0][35:4]));
        check("flags", 64'(flags), 64'(exp_q[0][3:0]));
        void'(exp_q.pop_front());
      end
    end
    acc = v && in_ready;
    if (acc) exp_q.push_back(use_model ? ref_add(a, b, s) : expv);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0, acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic latency_check(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic [35:0] expv);
    in_valid = 1'b1; op1 = a; op2 = b; sub = s; out_ready = 1'b1;
    #1;
    check("lat_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("lat_early", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_result", 64'(result), 64'(expv[35:4]));
    check("lat_flags", 64'(flags), 64'(expv[3:0]));
    @(posedge clk); #1;
    check("lat_consumed", 64'(out_valid), 64'd0);
  endtask

  logic [31:0] dir_a[11] = '{32'h3F800000, 32'h3F800000, 32'h00C00000, 32'h3F800000, 32'h3F800000,
                             32'h7F7FFFFF, 32'h7F800000, 32'h7FA00000, 32'hBF800000, 32'h80000000,
                             32'hFF800000};
  logic [31:0] dir_b[11] = '{32'h40000000, 32'h3F800000, 32'h00BFFFFF, 32'h33800000, 32'h33C00000,
                             32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                             32'h3F800000};
  logic        dir_s[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [35:0] dir_e[11] = '{{32'h40400000, 4'b0000}, {32'h00000000, 4'b0000},
                             {32'h00000000, 4'b0011}, {32'h3F800000, 4'b0001},
                             {32'h3F800001, 4'b0001}, {32'h7F800000, 4'b0101},
                             {32'h7FC00000, 4'b1000}, {32'h7FC00000, 4'b1000},
                             {32'h00000000, 4'b0000}, {32'h80000000, 4'b0000},
                             {32'hFF800000, 4'b0000}};
  logic [31:0] spec_v[7] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                             32'h7FC00000, 32'h00000001, 32'h3F800000};

  initial begin
    logic acc, ordy, v, s;
    logic [31:0] a, b, bp_a[5], bp_b[5];
    int sent, stall, e;

    // Reset state
    #22;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    latency_check(32'h3F800000, 32'h40000000, 1'b0, {32'h40400000, 4'b0000});

    // Directed corner cases, back to back
    for (int i = 0; i < 11; i++) step(1'b1, dir_a[i], dir_b[i], dir_s[i], 1'b1, dir_e[i], 1'b0, acc);
    drain();

    // Back-pressure: five ops, output stalled six cycles from first out_valid
    for (int i = 0; i < 5; i++) begin bp_a[i] = rnd_num(100, 150); bp_b[i] = rnd_num(100, 150); end
    sent = 0; stall = 0;
    for (int c = 0; c < 40; c++) begin
      ordy = 1'b1;
      if (out_valid && stall < 6) begin
        ordy = 1'b0;
        check("bp_hold", 64'({result, flags}), 64'(exp_q[0]));
        stall++;
      end
      step(sent < 5, bp_a[sent % 5], bp_b[sent % 5], 1'b0, ordy, '0, 1'b1, acc);
      if (acc) sent++;
    end
    check("bp_sent", 64'(sent), 64'd5);
    check("bp_stalls", 64'(stall), 64'd6);
    drain();

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = $urandom; end
        1, 2: begin
          a = rnd_num(1, 254);
          e = int'(a[30:23]) + int'($urandom_range(0, 4)) - 2;
          if (e < 1) e = 1;
          if (e > 254) e = 254;
          b = {1'($urandom), 8'(e), 23'($urandom)};
        end
        3: begin
          a = rnd_num(40, 254);
          e = int'(a[30:23]) - int'($urandom_range(20, 30));
          b = {1'($urandom), 8'(e), 23'($urandom)};
        end
        4: begin
          a = spec_v[$urandom_range(0, 6)];
          b = ($urandom_range(0, 1) == 1) ? spec_v[$urandom_range(0, 6)] : rnd_num(1, 254);
        end
        default: begin
          a = ($urandom_range(0, 1) == 1) ? rnd_num(240, 254) : rnd_num(1, 5);
          b = ($urandom_range(0, 1) == 1) ? rnd_num(240, 254) : rnd_num(1, 5);
        end
      endcase
      if ($urandom_range(0, 1) == 1) begin a = b ^ 32'h80000000; end
      s = 1'($urandom);
      v = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 4) != 0);
      step(v, a, b, s, ordy, '0, 1'b1, acc);
    end
    drain();

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) step(1'b1, rnd_num(100, 150), rnd_num(100, 150), 1'b0, 1'b1, '0, 1'b1, acc);
    for (int k = 0; k < 6 && !out_valid; k++) step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, acc);
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_result", 64'(result), 64'd0);
    check("mid_flags", 64'(flags), 64'd0);
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      check("post_rst_idle", 64'(out_valid), 64'd0);
      step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0, acc);
    end
    latency_check(32'h3F800000, 32'h33C00000, 1'b0, {32'h3F800001, 4'b0001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
